// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA layer compositor.
// Colour/count widths, default layer count and config FSM states.
package vga_pkg;

  localparam int RGB_W        = 12;
  localparam int HC_W         = 11;
  localparam int VC_W         = 11;
  localparam int N_LAYERS_DEF = 4;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 12'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    REL  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/itf_vga.sv
// itf_vga: one VGA pixel-stream beat (timing plus colour).
// The in/out modports are the consumer and producer views.
interface itf_vga;
  import vga_pkg::*;

  logic [HC_W-1:0]  hcount;
  logic [VC_W-1:0]  vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic [RGB_W-1:0] rgb;

  modport in (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );

endinterface

// File: rtl/vga_cfg_shadow.sv
// vga_cfg_shadow: frame-boundary detector and req/ack shadow config.
// Layer enable and background only change on a vblank rising edge.
module vga_cfg_shadow #(
  parameter int N_LAYERS = 4,
  parameter int RGB_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vblnk_i,
  input  logic                cfg_req_i,
  input  logic [N_LAYERS-1:0] cfg_enable_i,
  input  logic [RGB_W-1:0]    cfg_bg_rgb_i,
  output logic [N_LAYERS-1:0] act_en_o,
  output logic [RGB_W-1:0]    act_bg_o,
  output logic                cfg_ack_o,
  output logic                frame_start_o
);
  import vga_pkg::*;

  cfg_state_t          state_q, state_d;
  logic                vblnk_q;
  logic                fb;
  logic                load;
  logic [N_LAYERS-1:0] act_en_q, act_en_d;
  logic [RGB_W-1:0]    act_bg_q, act_bg_d;
  logic                ack_q;
  logic                fs_q;

  // vblnk_q resets high so leaving reset inside
  // the active area never looks like a boundary
  assign fb = vblnk_i & ~vblnk_q;

  // next state: arm on request, load on boundary,
  // then wait for the requester to release
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_req_i && fb) begin
          load    = 1'b1;
          state_d = REL;
        end else if (cfg_req_i) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (!cfg_req_i) begin
          state_d = IDLE;
        end else if (fb) begin
          load    = 1'b1;
          state_d = REL;
        end
      end
      REL: begin
        if (!cfg_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // shadow -> active copy on load only
  always_comb begin
    act_en_d = act_en_q;
    act_bg_d = act_bg_q;
    if (load) begin
      act_en_d = cfg_enable_i;
      act_bg_d = cfg_bg_rgb_i;
    end
  end

  // state, active config and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vblnk_q  <= 1'b1;
      act_en_q <= '1;
      act_bg_q <= RGB_W'(COLOR_BLACK);
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vblnk_q  <= vblnk_i;
      act_en_q <= act_en_d;
      act_bg_q <= act_bg_d;
      ack_q    <= load;
      fs_q     <= fb;
    end
  end

  assign act_en_o      = act_en_q;
  assign act_bg_o      = act_bg_q;
  assign cfg_ack_o     = ack_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter: fixed-priority layer compositor, one-cycle
// registered VGA output with frame-synchronous configuration.
module vga_layer_arbiter #(
  parameter int N_LAYERS = vga_pkg::N_LAYERS_DEF,
  parameter int RGB_W    = vga_pkg::RGB_W
) (
  input  logic                           clk,
  input  logic                           rst,
  itf_vga.in                             vga_in,
  input  logic [N_LAYERS-1:0][RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]            layer_valid,
  input  logic [N_LAYERS-1:0]            cfg_enable,
  input  logic [RGB_W-1:0]               cfg_bg_rgb,
  input  logic                           cfg_req,
  output logic                           cfg_ack,
  output logic                           frame_start,
  itf_vga.out                            vga_out
);
  import vga_pkg::*;

  logic [N_LAYERS-1:0] act_en;
  logic [RGB_W-1:0]    act_bg;
  logic [RGB_W-1:0]    pix_d, pix_q;
  logic                hit;
  logic [HC_W-1:0]     hc_q;
  logic [VC_W-1:0]     vc_q;
  logic                hs_q, vs_q;
  logic                hb_q, vb_q;
  logic                unused_rgb;

  // incoming colour is replaced by the composite
  assign unused_rgb = ^vga_in.rgb;

  vga_cfg_shadow #(
    .N_LAYERS (N_LAYERS),
    .RGB_W    (RGB_W)
  ) u_shadow (
    .clk           (clk),
    .rst           (rst),
    .vblnk_i       (vga_in.vblnk),
    .cfg_req_i     (cfg_req),
    .cfg_enable_i  (cfg_enable),
    .cfg_bg_rgb_i  (cfg_bg_rgb),
    .act_en_o      (act_en),
    .act_bg_o      (act_bg),
    .cfg_ack_o     (cfg_ack),
    .frame_start_o (frame_start)
  );

  // lowest enabled opaque layer wins; black in blanking
  always_comb begin
    pix_d = act_bg;
    hit   = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (!hit && act_en[i] && layer_valid[i]) begin
        pix_d = layer_rgb[i];
        hit   = 1'b1;
      end
    end
    if (vga_in.hblnk || vga_in.vblnk) begin
      pix_d = RGB_W'(COLOR_BLACK);
    end
  end

  // output pipeline keeps timing aligned with colour
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      hb_q  <= 1'b0;
      vb_q  <= 1'b0;
    end else begin
      pix_q <= pix_d;
      hc_q  <= vga_in.hcount;
      vc_q  <= vga_in.vcount;
      hs_q  <= vga_in.hsync;
      vs_q  <= vga_in.vsync;
      hb_q  <= vga_in.hblnk;
      vb_q  <= vga_in.vblnk;
    end
  end

  assign vga_out.rgb    = pix_q;
  assign vga_out.hcount = hc_q;
  assign vga_out.vcount = vc_q;
  assign vga_out.hsync  = hs_q;
  assign vga_out.vsync  = vs_q;
  assign vga_out.hblnk  = hb_q;
  assign vga_out.vblnk  = vb_q;

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// tb_vga_layer_arbiter: random raster/layer stimulus against a
// frame-level reference model, plus directed handshake scenarios.
module tb_vga_layer_arbiter;
  import vga_pkg::*;

  localparam int NL    = 4;
  localparam int H_TOT = 16;
  localparam int H_ACT = 10;
  localparam int V_TOT = 8;
  localparam int V_ACT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itf_vga vin();
  itf_vga vout();

  logic [NL-1:0][RGB_W-1:0] layer_rgb;
  logic [NL-1:0]            layer_valid;
  logic [NL-1:0]            cfg_enable;
  logic [RGB_W-1:0]         cfg_bg_rgb;
  logic                     cfg_req;
  logic                     cfg_ack;
  logic                     frame_start;

  vga_layer_arbiter #(
    .N_LAYERS (NL),
    .RGB_W    (RGB_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vin),
    .layer_rgb   (layer_rgb),
    .layer_valid (layer_valid),
    .cfg_enable  (cfg_enable),
    .cfg_bg_rgb  (cfg_bg_rgb),
    .cfg_req     (cfg_req),
    .cfg_ack     (cfg_ack),
    .frame_start (frame_start),
    .vga_out     (vout)
  );

  int n_chk = 0;
  int n_err = 0;
  int hc = 0;
  int vc = 0;
  bit rnd = 1'b1;
  int n_ack = 0;
  int n_fs = 0;

  // reference state: active config, previous vblank, and
  // whether the requester has been seen low since last ack
  logic [NL-1:0]    m_en;
  logic [RGB_W-1:0] m_bg;
  bit               m_vprev;
  bit               m_armed;
  logic [RGB_W-1:0] e_rgb;
  logic [25:0]      e_tim;
  bit               e_ack, e_fs;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h @%0t",
                 tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit fb;
    int win;
    if (rst) begin
      e_rgb = '0; e_tim = '0; e_ack = 0; e_fs = 0;
      m_en = '1; m_bg = '0; m_vprev = 1; m_armed = 1;
    end else begin
      fb = vin.vblnk && !m_vprev;
      win = -1;
      for (int i = NL - 1; i >= 0; i--)
        if (m_en[i] && layer_valid[i]) win = i;
      if (vin.hblnk || vin.vblnk) e_rgb = 12'h000;
      else if (win < 0)           e_rgb = m_bg;
      else                        e_rgb = layer_rgb[win];
      e_tim = {vin.hcount, vin.vcount, vin.hsync,
               vin.vsync, vin.hblnk, vin.vblnk};
      e_fs  = fb;
      e_ack = fb && cfg_req && m_armed;
      if (e_ack) begin
        m_en = cfg_enable; m_bg = cfg_bg_rgb; m_armed = 0;
      end else if (!cfg_req) begin
        m_armed = 1;
      end
      m_vprev = vin.vblnk;
    end
  endtask

  task automatic cyc();
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vc);
    vin.hblnk  = hc >= H_ACT;
    vin.vblnk  = vc >= V_ACT;
    vin.hsync  = (hc == 12) || (hc == 13);
    vin.vsync  = vc == 6;
    vin.rgb    = 12'($urandom);
    if (rnd) begin
      for (int i = 0; i < NL; i++) layer_rgb[i] = 12'($urandom);
      layer_valid = 4'($urandom);
    end
    model_eval();
    @(posedge clk);
    #1;
    check("rgb", 32'(vout.rgb), 32'(e_rgb));
    check("timing", 32'({vout.hcount, vout.vcount, vout.hsync,
          vout.vsync, vout.hblnk, vout.vblnk}), 32'(e_tim));
    check("ack", 32'(cfg_ack), 32'(e_ack));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    n_ack += int'(cfg_ack);
    n_fs  += int'(frame_start);
    hc++;
    if (hc == H_TOT) begin
      hc = 0;
      vc = (vc + 1) % V_TOT;
    end
  endtask

  task automatic run_to(int v, int h);
    for (int k = 0; k < 3 * H_TOT * V_TOT; k++) begin
      if (hc == h && vc == v) return;
      cyc();
    end
    check("run_to_timeout", 32'd1, 32'd0);
  endtask

  task automatic pix(logic [NL-1:0] vld, string tag,
                     logic [RGB_W-1:0] exp);
    rnd = 0;
    layer_valid = vld;
    cyc();
    check(tag, 32'(vout.rgb), 32'(exp));
    rnd = 1;
  endtask

  bit got_ack;

  initial begin
    rst = 1; cfg_req = 0; cfg_enable = '0; cfg_bg_rgb = '0;
    layer_valid = '0; layer_rgb = '0;
    repeat (3) cyc();
    check("rst_rgb", 32'(vout.rgb), 32'h0);
    check("rst_vblnk", 32'(vout.vblnk), 32'h0);
    check("rst_ack", 32'(cfg_ack), 32'h0);
    rst = 0;
    n_fs = 0;
    run_to(V_ACT, 0);
    check("no_early_fs", 32'(n_fs), 32'd0);
    cyc();
    check("first_fs", 32'(frame_start), 32'd1);

    // priority and position alignment
    hc = 3; vc = 2;
    layer_rgb[0] = 12'h123; layer_rgb[1] = 12'hF00;
    layer_rgb[2] = 12'h0F0; layer_rgb[3] = 12'h00F;
    pix(4'b0110, "prio_rgb", 12'hF00);
    check("prio_hc", 32'(vout.hcount), 32'd3);
    check("prio_vc", 32'(vout.vcount), 32'd2);
    hc = H_ACT + 1; vc = 2;
    pix(4'b1111, "hblank_black", 12'h000);
    hc = 4; vc = 3;
    pix(4'b0000, "bg_reset", 12'h000);

    // mid-frame request, loaded on the next boundary
    run_to(1, 0);
    cfg_enable = 4'b0100; cfg_bg_rgb = 12'h00F; cfg_req = 1;
    n_ack = 0;
    run_to(V_ACT, 0);
    check("ack_before_vb", 32'(n_ack), 32'd0);
    cyc();
    check("ack_at_fb", 32'(cfg_ack), 32'd1);
    check("fs_with_ack", 32'(frame_start), 32'd1);
    n_ack = 0;
    run_to(2, 3);
    layer_rgb[1] = 12'hF00;
    pix(4'b0010, "new_bg", 12'h00F);
    run_to(V_ACT + 1, 0);
    check("no_second_ack", 32'(n_ack), 32'd0);
    cfg_req = 0;
    repeat (2) cyc();

    // request rising together with vblank
    run_to(V_ACT, 0);
    cfg_enable = 4'b1011; cfg_bg_rgb = 12'h0A5; cfg_req = 1;
    cyc();
    check("simul_ack", 32'(cfg_ack), 32'd1);
    cfg_req = 0;
    cyc();

    // request withdrawn before the boundary
    run_to(1, 0);
    cfg_enable = 4'b0000; cfg_bg_rgb = 12'hFFF; cfg_req = 1;
    repeat (5) cyc();
    cfg_req = 0;
    n_ack = 0;
    run_to(V_ACT + 1, 0);
    check("abort_no_ack", 32'(n_ack), 32'd0);
    run_to(2, 3);
    pix(4'b0000, "abort_bg", 12'h0A5);
    layer_rgb[0] = 12'h321; layer_rgb[2] = 12'h456;
    pix(4'b0101, "abort_en", 12'h321);
    pix(4'b0100, "abort_dis", 12'h0A5);

    // reset while pending
    run_to(1, 0);
    cfg_enable = 4'b0000; cfg_bg_rgb = 12'hFFF; cfg_req = 1;
    repeat (3) cyc();
    rst = 1;
    repeat (2) cyc();
    rst = 0; cfg_req = 0;
    n_ack = 0;
    run_to(V_ACT + 1, 0);
    check("rst_pend_ack", 32'(n_ack), 32'd0);
    run_to(2, 3);
    pix(4'b0000, "rst_bg", 12'h000);
    layer_rgb[3] = 12'hABC;
    pix(4'b1000, "rst_en", 12'hABC);

    // random soak with a well-behaved requester
    got_ack = 0;
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 1499) == 0);
      if (!cfg_req) begin
        if ($urandom_range(0, 39) == 0) begin
          cfg_enable = 4'($urandom);
          cfg_bg_rgb = 12'($urandom);
          cfg_req = 1;
          got_ack = 0;
        end
      end else if (got_ack) begin
        if ($urandom_range(0, 3) == 0) cfg_req = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        cfg_req = 0;
      end
      cyc();
      if (cfg_ack) got_ack = 1;
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
